// File: rtl/beehive_vr_pkg.sv
// beehive_vr_pkg: shared VR message types, UDP header layout and dispatch FSM states
package beehive_vr_pkg;
  localparam int VR_MSG_TYPE_W = 8;
  localparam int NOC_PADBYTES_W = 6;
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;
  typedef enum logic [VR_MSG_TYPE_W-1:0] {
    VR_MSG_PREPARE = 8'd3,
    VR_MSG_COMMIT  = 8'd5
  } vr_msg_type_e;
  typedef enum logic [3:0] {
    IDLE, TYPE, WAIT_C, WAIT_P, HDR_C, HDR_P, STREAM_C, STREAM_P, DRAIN
  } dispatch_state_e;
endpackage

// File: rtl/vr_msg_dispatch_ctrl.sv
// vr_msg_dispatch_ctrl: dispatch FSM plus ready/valid steering between source and engines
//   in : hdr_val, data_val/data_last (source), flit_type (first-flit type), type_reg,
//        *_eng_rdy, *_msg_rdy, *_req_rdy (engines)
//   out: state, hdr_rdy/data_rdy (to source), *_msg_val/*_req_val (to engines)
module vr_msg_dispatch_ctrl
  import beehive_vr_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hdr_val,
  input  logic                     data_val,
  input  logic                     data_last,
  input  logic [VR_MSG_TYPE_W-1:0] flit_type,
  input  logic [VR_MSG_TYPE_W-1:0] type_reg,
  input  logic                     commit_eng_rdy,
  input  logic                     prep_eng_rdy,
  input  logic                     commit_msg_rdy,
  input  logic                     prep_msg_rdy,
  input  logic                     commit_req_rdy,
  input  logic                     prep_req_rdy,
  output dispatch_state_e          state,
  output logic                     hdr_rdy,
  output logic                     data_rdy,
  output logic                     commit_msg_val,
  output logic                     prep_msg_val,
  output logic                     commit_req_val,
  output logic                     prep_req_val
);
  logic is_c, is_p, wait_c, eng_ok, data_hs;
  always_comb begin
    is_c = flit_type == VR_MSG_COMMIT;
    is_p = flit_type == VR_MSG_PREPARE;
    wait_c = type_reg == VR_MSG_COMMIT;
    eng_ok = wait_c ? commit_eng_rdy : prep_eng_rdy;
    commit_req_val = state == STREAM_C && data_val;
    prep_req_val = state == STREAM_P && data_val;
    data_rdy = state == STREAM_C ? commit_req_rdy : state == STREAM_P ? prep_req_rdy : state == DRAIN;
    data_hs = data_val && data_rdy;
  end
  // hdr_rdy and msg_val are registered; the TYPE state only peeks at the first flit,
  // and skips WAIT when the chosen engine is already idle so msg_val lands at N+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hdr_rdy <= 1'b0;
      commit_msg_val <= 1'b0;
      prep_msg_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hdr_rdy <= !(hdr_val && hdr_rdy);
          if (hdr_val && hdr_rdy) state <= TYPE;
        end
        TYPE: if (data_val) begin
          state <= is_c ? (commit_eng_rdy ? HDR_C : WAIT_C) : is_p ? (prep_eng_rdy ? HDR_P : WAIT_P) : DRAIN;
          commit_msg_val <= is_c && commit_eng_rdy;
          prep_msg_val <= is_p && prep_eng_rdy;
        end
        WAIT_C, WAIT_P: if (eng_ok) begin
          state <= wait_c ? HDR_C : HDR_P;
          commit_msg_val <= wait_c;
          prep_msg_val <= !wait_c;
        end
        HDR_C: if (commit_msg_rdy) begin
          state <= STREAM_C;
          commit_msg_val <= 1'b0;
        end
        HDR_P: if (prep_msg_rdy) begin
          state <= STREAM_P;
          prep_msg_val <= 1'b0;
        end
        STREAM_C, STREAM_P, DRAIN: if (data_hs && data_last) begin
          state <= IDLE;
          hdr_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vr_msg_dispatch.sv
// vr_msg_dispatch: route one UDP packet (header + NoC stream) to commit or prepare engine by VR type
//   source side : src_dispatch_hdr_val/pkt_info -> dispatch_src_hdr_rdy,
//                 src_dispatch_data_val/data/last/padbytes -> dispatch_src_data_rdy
//   commit side : manage_commit_msg_val/pkt_info, manage_commit_req_val/req/last/padbytes
//   prep side   : manage_prep_msg_val/pkt_info, manage_prep_req_val/req/last/padbytes
//   status      : dispatch_drop_cnt (saturating count of unknown-type packets)
module vr_msg_dispatch
  import beehive_vr_pkg::*;
#(
  parameter int NOC_DATA_W = -1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_dispatch_hdr_val,
  input  udp_info                   src_dispatch_pkt_info,
  output logic                      dispatch_src_hdr_rdy,
  input  logic                      src_dispatch_data_val,
  input  logic [NOC_DATA_W-1:0]     src_dispatch_data,
  input  logic                      src_dispatch_data_last,
  input  logic [NOC_PADBYTES_W-1:0] src_dispatch_data_padbytes,
  output logic                      dispatch_src_data_rdy,
  output logic                      manage_commit_msg_val,
  output udp_info                   manage_commit_pkt_info,
  input  logic                      commit_manage_msg_rdy,
  output logic                      manage_commit_req_val,
  output logic [NOC_DATA_W-1:0]     manage_commit_req,
  output logic                      manage_commit_req_last,
  output logic [NOC_PADBYTES_W-1:0] manage_commit_req_padbytes,
  input  logic                      commit_manage_req_rdy,
  output logic                      manage_prep_msg_val,
  output udp_info                   manage_prep_pkt_info,
  input  logic                      prep_manage_msg_rdy,
  output logic                      manage_prep_req_val,
  output logic [NOC_DATA_W-1:0]     manage_prep_req,
  output logic                      manage_prep_req_last,
  output logic [NOC_PADBYTES_W-1:0] manage_prep_req_padbytes,
  input  logic                      prep_manage_req_rdy,
  input  logic                      commit_eng_rdy,
  input  logic                      prep_eng_rdy,
  output logic [15:0]               dispatch_drop_cnt
);
  if (NOC_DATA_W < VR_MSG_TYPE_W) begin : g_bad_width
    $error("vr_msg_dispatch: NOC_DATA_W must be >= VR_MSG_TYPE_W");
  end
  dispatch_state_e state;
  udp_info hdr_reg;
  logic [VR_MSG_TYPE_W-1:0] flit_type, type_reg;
  assign flit_type = src_dispatch_data[NOC_DATA_W-1 -: VR_MSG_TYPE_W];
  assign manage_commit_pkt_info = hdr_reg;
  assign manage_prep_pkt_info = hdr_reg;
  // Data lines fan out to both engines; only the selected engine's val is ever raised.
  assign manage_commit_req = src_dispatch_data;
  assign manage_commit_req_last = src_dispatch_data_last;
  assign manage_commit_req_padbytes = src_dispatch_data_padbytes;
  assign manage_prep_req = src_dispatch_data;
  assign manage_prep_req_last = src_dispatch_data_last;
  assign manage_prep_req_padbytes = src_dispatch_data_padbytes;
  vr_msg_dispatch_ctrl u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .hdr_val        (src_dispatch_hdr_val),
    .data_val       (src_dispatch_data_val),
    .data_last      (src_dispatch_data_last),
    .flit_type      (flit_type),
    .type_reg       (type_reg),
    .commit_eng_rdy (commit_eng_rdy),
    .prep_eng_rdy   (prep_eng_rdy),
    .commit_msg_rdy (commit_manage_msg_rdy),
    .prep_msg_rdy   (prep_manage_msg_rdy),
    .commit_req_rdy (commit_manage_req_rdy),
    .prep_req_rdy   (prep_manage_req_rdy),
    .state          (state),
    .hdr_rdy        (dispatch_src_hdr_rdy),
    .data_rdy       (dispatch_src_data_rdy),
    .commit_msg_val (manage_commit_msg_val),
    .prep_msg_val   (manage_prep_msg_val),
    .commit_req_val (manage_commit_req_val),
    .prep_req_val   (manage_prep_req_val)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_reg <= '0;
      type_reg <= '0;
      dispatch_drop_cnt <= '0;
    end else begin
      if (src_dispatch_hdr_val && dispatch_src_hdr_rdy) hdr_reg <= src_dispatch_pkt_info;
      if (state == TYPE && src_dispatch_data_val) type_reg <= flit_type;
      if (state == DRAIN && src_dispatch_data_val && src_dispatch_data_last && dispatch_drop_cnt != 16'hFFFF)
        dispatch_drop_cnt <= dispatch_drop_cnt + 16'd1;
    end
  end
endmodule
